// File: rtl/wb_seq_ctrl.sv
// Writeback/memory sequencing controller: decides writeback select and register
// write enable, and stalls the pipeline while a load or store is outstanding.
module wb_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_valid,
  input  logic [1:0] wb_src,
  input  logic       reg_write,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       mem_ack,
  input  logic       err_clr,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] wb_sel,
  output logic       rf_we,
  output logic       stall,
  output logic       mem_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_WAIT = 2'b01,
    WB       = 2'b10,
    ERR      = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               rw_q, rw_d;
  logic               we_q, we_d;
  logic [SEL_W-1:0]   src_sel;

  // Loads always write back memory data; the unused encoding folds onto the ALU.
  assign src_sel = mem_read ? 2'b01 : ((wb_src == 2'b11) ? 2'b00 : wb_src);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      rw_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rw_q    <= rw_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rw_d    = rw_q;
    we_d    = we_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    wb_sel  = 2'b00;
    rf_we   = 1'b0;
    stall   = 1'b0;
    mem_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          wb_sel = src_sel;
          if (mem_read && mem_write) begin
            stall   = 1'b1;
            state_d = ERR;
          end else if (mem_read || mem_write) begin
            stall   = 1'b1;
            sel_d   = src_sel;
            rw_d    = reg_write;
            we_d    = mem_write;
            cnt_d   = CNT_W'(1);
            state_d = MEM_WAIT;
          end else begin
            rf_we = reg_write;
          end
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        stall   = 1'b1;
        wb_sel  = sel_q;
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_d = WB;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        wb_sel  = sel_q;
        rf_we   = rw_q & ~we_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      ERR: begin
        mem_err = 1'b1;
        stall   = 1'b1;
        if (err_clr) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs must read zero while reset is held, even with live decode inputs.
    if (!reset_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      wb_sel  = 2'b00;
      rf_we   = 1'b0;
      stall   = 1'b0;
      mem_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Randomized bench for wb_seq_ctrl; expected output sequences are derived per
// transaction from the ack latency and the timeout limit.
module tb_wb_seq_ctrl;

  localparam int T = 4;

  logic       clk, reset_n;
  logic       instr_valid, reg_write, mem_read, mem_write, mem_ack, err_clr;
  logic [1:0] wb_src;
  logic       mem_req, mem_we, rf_we, stall, mem_err;
  logic [1:0] wb_sel;
  logic [6:0] outv;

  int n_checks = 0;
  int n_pass   = 0;

  wb_seq_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .wb_src(wb_src),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ack(mem_ack), .err_clr(err_clr), .mem_req(mem_req), .mem_we(mem_we),
    .wb_sel(wb_sel), .rf_we(rf_we), .stall(stall), .mem_err(mem_err)
  );

  assign outv = {mem_req, mem_we, wb_sel, rf_we, stall, mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got {req,we,sel,rf,stall,err}=%b want %b at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] ev(input logic req, input logic we, input logic [1:0] sel,
                                    input logic rf, input logic st, input logic er);
    return {req, we, sel, rf, st, er};
  endfunction

  function automatic logic [1:0] map_sel(input logic [1:0] src, input logic mr);
    if (mr) return 2'b01;
    if (src == 2'b11) return 2'b00;
    return src;
  endfunction

  task automatic cyc(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check_eq(tag, outv, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_decode();
    instr_valid = 1'($urandom);
    wb_src      = 2'($urandom);
    reg_write   = 1'($urandom);
    mem_read    = 1'($urandom);
    mem_write   = 1'($urandom);
  endtask

  task automatic err_phase(input int nerr);
    for (int i = 0; i < nerr; i++) begin
      rand_decode();
      mem_ack = 1'($urandom);
      err_clr = 1'b0;
      cyc("err_hold", ev(0, 0, 2'b00, 0, 1, 1));
    end
    rand_decode();
    mem_ack = 1'($urandom);
    err_clr = 1'b1;
    cyc("err_clr", ev(0, 0, 2'b00, 0, 1, 1));
  endtask

  // lat = MEM_WAIT cycle carrying the ack (1-based); 0 or > T means no ack in time.
  task automatic do_txn(input logic iv, input logic [1:0] src, input logic rw,
                        input logic mr, input logic mw, input int lat, input int nerr);
    logic [1:0] sel;
    bit acked;
    sel = map_sel(src, mr);
    instr_valid = iv; wb_src = src; reg_write = rw; mem_read = mr; mem_write = mw;
    mem_ack = 1'($urandom);
    err_clr = 1'($urandom);
    if (!iv) begin
      cyc("idle", ev(0, 0, 2'b00, 0, 0, 0));
    end else if (mr && mw) begin
      cyc("illegal", ev(0, 0, sel, 0, 1, 0));
      err_phase(nerr);
    end else if (!(mr || mw)) begin
      cyc("alu", ev(0, 0, sel, rw, 0, 0));
    end else begin
      cyc("issue", ev(0, 0, sel, 0, 1, 0));
      acked = 1'b0;
      for (int k = 1; k <= T; k++) begin
        rand_decode();
        mem_ack = (k == lat);
        err_clr = 1'($urandom);
        cyc("mem_wait", ev(1, mw, sel, 0, 1, 0));
        if (k == lat) begin
          acked = 1'b1;
          break;
        end
      end
      if (acked) begin
        rand_decode();
        mem_ack = 1'($urandom);
        err_clr = 1'($urandom);
        cyc("wb", ev(0, 0, sel, rw & ~mw, 0, 0));
      end else begin
        err_phase(nerr);
      end
    end
  endtask

  // Assert reset between edges, confirm outputs drop at once, release away from an edge.
  task automatic async_reset(input string tag);
    instr_valid = 1'b1; reg_write = 1'b1; wb_src = 2'b10; mem_read = 1'b0; mem_write = 1'b0;
    mem_ack = 1'b0; err_clr = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq(tag, outv, 7'b0);
    @(negedge clk);
    check_eq({tag, "_held"}, outv, 7'b0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int kind;
    logic mr, mw;
    reset_n = 1'b0;
    instr_valid = 1'b1; wb_src = 2'b01; reg_write = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
    #3;
    check_eq("reset_state", outv, 7'b0);
    #9;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_txn(1, 2'b00, 1, 0, 0, 0, 0);   // ALU add
    do_txn(1, 2'b10, 1, 1, 0, 3, 0);   // load, 3-cycle latency
    do_txn(1, 2'b00, 1, 0, 1, 1, 0);   // store, immediate ack
    do_txn(1, 2'b00, 1, 1, 0, 0, 2);   // load timeout then clear
    do_txn(0, 2'b00, 0, 0, 0, 0, 0);   // back in IDLE, mem_err low
    do_txn(1, 2'b01, 1, 1, 0, T, 0);   // ack on the timeout cycle
    do_txn(1, 2'b00, 1, 1, 1, 0, 1);   // illegal read+write
    do_txn(1, 2'b11, 1, 0, 0, 0, 0);   // unused source folds to ALU
    do_txn(1, 2'b10, 0, 0, 0, 0, 0);   // PC+4, no register write

    // Reset mid MEM_WAIT.
    instr_valid = 1; wb_src = 2'b00; reg_write = 1; mem_read = 1; mem_write = 0; mem_ack = 0;
    cyc("rst_issue", ev(0, 0, 2'b01, 0, 1, 0));
    mem_ack = 0;
    cyc("rst_wait1", ev(1, 0, 2'b01, 0, 1, 0));
    async_reset("rst_mid_wait");
    do_txn(1, 2'b10, 1, 0, 0, 0, 0);

    // Reset while in ERR.
    instr_valid = 1; mem_read = 1; mem_write = 1; wb_src = 2'b00;
    cyc("rst_illegal", ev(0, 0, 2'b01, 0, 1, 0));
    err_clr = 0;
    cyc("rst_err", ev(0, 0, 2'b00, 0, 1, 1));
    async_reset("rst_in_err");
    do_txn(1, 2'b00, 1, 0, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      mr = (kind >= 4 && kind <= 6) || kind == 9;
      mw = (kind == 7 || kind == 8) || kind == 9;
      do_txn(1'($urandom_range(0, 9) != 0), 2'($urandom), 1'($urandom), mr, mw,
             $urandom_range(0, 6), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
